fetch_ctrl: RTL

Instruction-fetch sequencer for the pipelined ARM core. Sits between the `pc` register, the instruction memory and the IF/ID pipeline register. It drives PC load and next-PC value, runs a request/acknowledge handshake with a variable-latency instruction memory, and holds a fetched instruction while the hazard unit freezes the front end. It also redirects fetch on taken branches and flushes the front end.

---
 rtl/arm_pkg.sv | 19 +
 rtl/fetch_perf_cnt.sv | 17 +
 rtl/fetch_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM core front end: fetch FSM encoding and PC constants.
package arm_pkg;

    localparam logic [1:0] FC_RST_WAIT = 2'd0;
    localparam logic [1:0] FC_FETCH    = 2'd1;
    localparam logic [1:0] FC_HOLD     = 2'd2;
    localparam logic [1:0] FC_DRAIN    = 2'd3;

    localparam int unsigned DEF_PC_STEP  = 4;
    localparam logic [31:0] RESET_PC_VAL = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RST_WAIT = FC_RST_WAIT,
        ST_FETCH    = FC_FETCH,
        ST_HOLD     = FC_HOLD,
        ST_DRAIN    = FC_DRAIN
    } fc_state_t;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating 32-bit event counter for fetch performance monitoring.
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC stepping, imem req/ack handshake, freeze hold, branch redirect.
// Optional cycle counters are enabled with FETCH_CTRL_PERF_EN.
//
// state     | meaning
// RST_WAIT  | first cycle after reset, no request issued
// FETCH     | request at i_PC outstanding
// HOLD      | instruction buffered while IF/ID is frozen
// DRAIN     | waiting out a request abandoned by a branch
module fetch_ctrl
    import arm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PC_STEP    = DEF_PC_STEP
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_PC,
    input  logic                  i_Freeze,
    input  logic                  i_Branch_Taken,
    input  logic [DATA_WIDTH-1:0] i_Branch_Addr,
    input  logic                  i_Imem_Ack,
    input  logic [DATA_WIDTH-1:0] i_Imem_Data,
    output logic                  o_Imem_Req,
    output logic [DATA_WIDTH-1:0] o_Imem_Addr,
    output logic                  o_PC_Load,
    output logic [DATA_WIDTH-1:0] o_PC_Next,
    output logic                  o_IF_Valid,
    output logic [DATA_WIDTH-1:0] o_Instr,
`ifdef FETCH_CTRL_PERF_EN
    output logic [31:0]           o_Fetch_Count,
    output logic [31:0]           o_Stall_Count,
`endif
    output logic                  o_Flush
);

    fc_state_t             state, state_d;
    logic [DATA_WIDTH-1:0] hold_buf;
    logic [DATA_WIDTH-1:0] drain_addr;
    logic                  hold_we;
    logic                  drain_we;
    logic [DATA_WIDTH-1:0] pc_inc;

    assign pc_inc = i_PC + DATA_WIDTH'(PC_STEP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_RST_WAIT;
            hold_buf   <= '0;
            drain_addr <= DATA_WIDTH'(RESET_PC_VAL);
        end else begin
            state <= state_d;
            if (hold_we)  hold_buf   <= i_Imem_Data;
            if (drain_we) drain_addr <= i_PC;
        end
    end

    // Outputs are forced to 0 while reset is held, so a stray branch or ack cannot leak out.
    always_comb begin
        state_d     = state;
        o_Imem_Req  = 1'b0;
        o_Imem_Addr = '0;
        o_PC_Load   = 1'b0;
        o_PC_Next   = '0;
        o_IF_Valid  = 1'b0;
        o_Instr     = '0;
        o_Flush     = 1'b0;
        hold_we     = 1'b0;
        drain_we    = 1'b0;

        if (reset) begin
            case (state)
                ST_FETCH: begin
                    o_Imem_Req  = 1'b1;
                    o_Imem_Addr = i_PC;
                end
                ST_DRAIN: begin
                    o_Imem_Req  = 1'b1;
                    o_Imem_Addr = drain_addr;
                end
                default: ;
            endcase

            if (i_Branch_Taken) begin
                o_PC_Load = 1'b1;
                o_PC_Next = i_Branch_Addr;
                o_Flush   = 1'b1;
                if (state == ST_FETCH && !i_Imem_Ack) begin
                    drain_we = 1'b1;
                    state_d  = ST_DRAIN;
                end else if (state == ST_DRAIN) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_FETCH;
                end
            end else begin
                case (state)
                    ST_RST_WAIT: state_d = ST_FETCH;
                    ST_FETCH: begin
                        if (i_Imem_Ack) begin
                            if (i_Freeze) begin
                                hold_we = 1'b1;
                                state_d = ST_HOLD;
                            end else begin
                                o_IF_Valid = 1'b1;
                                o_Instr    = i_Imem_Data;
                                o_PC_Load  = 1'b1;
                                o_PC_Next  = pc_inc;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (!i_Freeze) begin
                            o_IF_Valid = 1'b1;
                            o_Instr    = hold_buf;
                            o_PC_Load  = 1'b1;
                            o_PC_Next  = pc_inc;
                            state_d    = ST_FETCH;
                        end
                    end
                    ST_DRAIN: begin
                        if (i_Imem_Ack) state_d = ST_FETCH;
                    end
                    default: state_d = ST_RST_WAIT;
                endcase
            end
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic stall_cycle;

    assign stall_cycle = (state == ST_HOLD) ||
                         (((state == ST_FETCH) || (state == ST_DRAIN)) && !i_Imem_Ack);

    fetch_perf_cnt u_fetch_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (o_IF_Valid),
        .count (o_Fetch_Count)
    );

    fetch_perf_cnt u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_cycle),
        .count (o_Stall_Count)
    );
`endif

endmodule
